// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
//
// Purpose : FSM state encoding and the step-counter width helper used by
//           serial_adder.
// Contents: state_t  - IDLE / RUN / DONE
//           cnt_width - bits needed to count WIDTH/DIGIT steps (at least 1)
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-step configuration (DIGIT == WIDTH) still needs a 1-bit counter.
    function automatic int cnt_width(input int width, input int digit);
        int w;
        w = $clog2(width / digit);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_fa_slice.sv
// rtl/serial_adder_fa_slice.sv - combinational DIGIT-bit ripple full-adder slice
//
// Purpose : one digit of the serial adder; DIGIT chained full-adder cells.
// Ports   : a_i, b_i   [DIGIT-1:0] operand digits
//           c_i                    carry into bit 0 of the slice
//           sum_o      [DIGIT-1:0] digit sum
//           c_o                    carry out of the slice
//           c_top_o                carry into the slice's top bit (for overflow)
module fa_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             c_o,
    output logic             c_top_o
);

    logic [DIGIT:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = c_i;
        for (int i = 0; i < DIGIT; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o     = c[DIGIT];
    assign c_top_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, DIGIT bits per clock
//
// Purpose : computes {cout,s} = a + b + cin (sub=0) or a + ~b + ~cin (sub=1)
//           over WIDTH/DIGIT cycles using one fa_slice, with valid/ready
//           handshakes on both sides.
// Ports   : clk, rst_n            clock, async active-low reset
//           in_valid / in_ready   operand handshake (a, b, cin, sub)
//           out_valid / out_ready result handshake (s, cout, ovf)
//           s [WIDTH-1:0]         sum or difference
//           cout                  carry-out (not a borrow when subtracting)
//           ovf                   two's-complement overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int             STEPS = WIDTH / DIGIT;
    localparam int             CW    = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0]  LAST  = CW'(STEPS - 1);

    generate
        if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH must be >= 2 and an integer multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_co;
    logic             dig_ctop;

    fa_slice #(.DIGIT(DIGIT)) u_slice (
        .a_i     (a_q[DIGIT-1:0]),
        .b_i     (b_q[DIGIT-1:0]),
        .c_i     (carry_q),
        .sum_o   (dig_sum),
        .c_o     (dig_co),
        .c_top_o (dig_ctop)
    );

    // DONE hands off and accepts in the same cycle, so readiness follows out_ready there.
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // New digit enters at the MSB end; after STEPS shifts it sits at the LSBs.
                s_d     = WIDTH'({dig_sum, s_q} >> DIGIT);
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d  = dig_co;
                    ovf_d   = dig_ctop ^ dig_co;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b ^ {WIDTH{sub}};
                        carry_d = cin ^ sub;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder (DIGIT=1 and DIGIT=4)
module tb_serial_adder;

    typedef struct {
        logic [7:0] s;
        logic       cout;
        logic       ovf;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    // DIGIT=1 instance
    logic       iv1 = 0, rdy1, ov1, or1 = 1, cin1 = 0, sub1 = 0, co1, of1;
    logic [7:0] a1 = 0, b1 = 0, s1;
    // DIGIT=4 instance
    logic       iv4 = 0, rdy4, ov4, or4 = 1, cin4 = 0, sub4 = 0, co4, of4;
    logic [7:0] a4 = 0, b4 = 0, s4;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    logic pv1 = 0, pv4 = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1),
        .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .out_valid(ov1), .out_ready(or1), .s(s1), .cout(co1), .ovf(of1)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(ov4), .out_ready(or4), .s(s4), .cout(co4), .ovf(of4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic ci, input logic su);
        exp_t       r;
        logic [7:0] bb;
        logic [8:0] t;
        bb     = su ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + {8'd0, su ? ~ci : ci};
        r.s    = t[7:0];
        r.cout = t[8];
        r.ovf  = (a[7] == bb[7]) && (t[7] != a[7]);
        r.acc  = 0;
        return r;
    endfunction

    // Monitors: latency at each out_valid rise, value check at each handoff.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ov1 && !pv1) begin
                if (q1.size() == 0) fail_now("d1 out_valid with no pending operation");
                else chk("d1 latency", cyc - q1[0].acc, 8);
            end
            if (ov1 && or1) begin
                if (q1.size() == 0) fail_now("d1 unexpected result");
                else begin
                    e1 = q1.pop_front();
                    chk("d1 s", int'(s1), int'(e1.s));
                    chk("d1 cout", int'(co1), int'(e1.cout));
                    chk("d1 ovf", int'(of1), int'(e1.ovf));
                end
            end
            if (ov4 && !pv4) begin
                if (q4.size() == 0) fail_now("d4 out_valid with no pending operation");
                else chk("d4 latency", cyc - q4[0].acc, 2);
            end
            if (ov4 && or4) begin
                if (q4.size() == 0) fail_now("d4 unexpected result");
                else begin
                    e4 = q4.pop_front();
                    chk("d4 s", int'(s4), int'(e4.s));
                    chk("d4 cout", int'(co4), int'(e4.cout));
                    chk("d4 ovf", int'(of4), int'(e4.ovf));
                end
            end
        end
        pv1 = ov1;
        pv4 = ov4;
    end

    task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic su, input exp_t e);
        int   t;
        exp_t x;
        t = 0;
        x = e;
        @(posedge clk); #1;
        if (d == 1) begin a1 = a; b1 = b; cin1 = ci; sub1 = su; iv1 = 1'b1; end
        else        begin a4 = a; b4 = b; cin4 = ci; sub4 = su; iv4 = 1'b1; end
        @(negedge clk);
        while (!((d == 1) ? rdy1 : rdy4) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!((d == 1) ? rdy1 : rdy4)) fail_now("in_ready timeout");
        else begin
            x.acc = cyc + 1;
            if (d == 1) q1.push_back(x);
            else        q4.push_back(x);
        end
        @(posedge clk); #1;
        if (d == 1) iv1 = 1'b0;
        else        iv4 = 1'b0;
    endtask

    function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o);
        exp_t r;
        r.s = s; r.cout = c; r.ovf = o; r.acc = 0;
        return r;
    endfunction

    task automatic drain(input int d);
        int t;
        t = 0;
        while (((d == 1) ? q1.size() : q4.size()) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain pending results", (d == 1) ? q1.size() : q4.size(), 0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc, rs;
        int         t;

        // Reset state
        #2;
        chk("rst in_ready d1", int'(rdy1), 1);
        chk("rst out_valid d1", int'(ov1), 0);
        chk("rst s d1", int'(s1), 0);
        chk("rst in_ready d4", int'(rdy4), 1);
        chk("rst out_valid d4", int'(ov4), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed DIGIT=1 vectors
        issue(1, 8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0));
        drain(1);
        issue(1, 8'h05, 8'h07, 1'b0, 1'b1, mk(8'hFE, 1'b0, 1'b0));
        drain(1);
        issue(1, 8'h05, 8'h07, 1'b1, 1'b1, mk(8'hFD, 1'b0, 1'b0));
        drain(1);
        issue(1, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1));
        drain(1);
        issue(1, 8'h80, 8'h01, 1'b0, 1'b1, mk(8'h7F, 1'b1, 1'b1));
        drain(1);
        issue(1, 8'h00, 8'h00, 1'b1, 1'b0, mk(8'h01, 1'b0, 1'b0));
        drain(1);

        // Backpressure, then hand-off with same-cycle accept
        @(posedge clk); #1 or1 = 1'b0;
        issue(1, 8'h3C, 8'h0F, 1'b0, 1'b0, mk(8'h4B, 1'b0, 1'b0));
        t = 0;
        while (!ov1 && t < 50) begin @(negedge clk); t++; end
        chk("bp out_valid seen", int'(ov1), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid held", int'(ov1), 1);
            chk("bp s stable", int'(s1), 8'h4B);
            chk("bp in_ready low", int'(rdy1), 0);
        end
        @(posedge clk); #1;
        or1 = 1'b1; a1 = 8'h40; b1 = 8'h40; cin1 = 1'b0; sub1 = 1'b0; iv1 = 1'b1;
        @(negedge clk);
        chk("b2b in_ready", int'(rdy1), 1);
        if (rdy1) begin
            e1 = mk(8'h80, 1'b0, 1'b1);
            e1.acc = cyc + 1;
            q1.push_back(e1);
        end
        @(posedge clk); #1 iv1 = 1'b0;
        drain(1);

        // Reset in the middle of RUN
        @(posedge clk); #1;
        a1 = 8'h11; b1 = 8'h22; cin1 = 1'b0; sub1 = 1'b0; iv1 = 1'b1;
        @(posedge clk); #1 iv1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun rst s", int'(s1), 0);
        chk("midrun rst cout", int'(co1), 0);
        chk("midrun rst ovf", int'(of1), 0);
        chk("midrun rst out_valid", int'(ov1), 0);
        chk("midrun rst in_ready", int'(rdy1), 1);
        q1.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post rst in_ready", int'(rdy1), 1);
        issue(1, 8'h12, 8'h34, 1'b0, 1'b0, mk(8'h46, 1'b0, 1'b0));
        drain(1);
        repeat (15) @(negedge clk);

        // DIGIT=4 sweep against the behavioural model
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (i == 0) begin ra = 8'hFF; rb = 8'h01; rc = 1'b0; rs = 1'b0; end
            if (i == 1) begin ra = 8'h80; rb = 8'h01; rc = 1'b0; rs = 1'b1; end
            issue(4, ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        drain(4);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
